debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Multi-channel, parametrised button conditioner. It is the successor to the single-input history debouncer and sits between raw board inputs (buttons, switches) and the display/control logic. Each channel has:
- a 2-flop synchroniser
- a prescaled sample tick shared across channels
- hysteretic history filtering
- one-cycle edge pulses
- long-press detection with optional auto-repeat

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
HIST_LEN, 8, consecutive identical samples required to change state (>=2)
PRESCALE, 1000, clk cycles per sample tick (>=1; 1 = sample every clk)
HOLD_TICKS, 500, ticks debounced must stay high before `held` pulses (0 = long-press disabled)
REPEAT_TICKS, 100, ticks between repeat pulses after long-press (0 = no repeat)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
buttons  input  CHANNELS  raw asynchronous inputs, active-high
debounced  output  CHANNELS  filtered level per channel
rise  output  CHANNELS  1-clk pulse on debounced 0->1
fall  output  CHANNELS  1-clk pulse on debounced 1->0
held  output  CHANNELS  1-clk pulse on long-press and on each repeat

Behaviour:
- Reset (async assert, sync use): all outputs 0, synchronisers 0, histories 0, prescaler 0, hold counters 0. No pulses are generated by reset release.
- Synchroniser: 2 flops per channel. `sync[i]` lags `buttons[i]` by 2 clk.
- Prescaler:
  - Counter runs 0..PRESCALE-1 and wraps.
  - `tick`=1 for one clk when counter==PRESCALE-1.
  - Counter width is clog2(PRESCALE), minimum 1.
- All channel state updates only on clock edges where `tick`=1. All outputs are registered.
- History: on tick, `hist[i] <= {hist[i][HIST_LEN-2:0], sync[i]}`. The comparison uses the post-shift value.
  - post-shift all ones and debounced=0 -> debounced<=1, rise<=1
  - post-shift all zeros and debounced=1 -> debounced<=0, fall<=1
  - otherwise debounced holds (hysteresis; bounces never toggle the output)
- Pulse width: rise, fall and held are high for exactly one clk, the cycle after the tick edge, then return to 0. This holds even when PRESCALE=1.
- Latency: a clean step on buttons appears on debounced after 2 + (HIST_LEN-1)*PRESCALE + 1 to 2 + HIST_LEN*PRESCALE clk.
- Hold counter (per channel):
  - Width is clog2(max(HOLD_TICKS, REPEAT_TICKS)+1).
  - Cleared whenever debounced is 0, including on the tick that sets debounced to 1.
  - On each tick while debounced=1, the counter increments.
  - When it reaches HOLD_TICKS: held<=1.
  - If REPEAT_TICKS>0: the counter reloads to HOLD_TICKS-REPEAT_TICKS (a repeat phase), so held pulses every REPEAT_TICKS ticks thereafter.
  - If REPEAT_TICKS=0: the counter saturates at HOLD_TICKS, and no further held pulses occur until release.
  - HOLD_TICKS=0: held is constantly 0 and the counter is removed.
- Release during hold: debounced falls, counter clears, no held pulse. A fall pulse is still issued.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset mid-operation: immediate clear of everything. An input still high after release re-qualifies from empty history, so rise fires again after HIST_LEN ticks (intended).
- Glitch shorter than HIST_LEN ticks of opposite value: no output change, no pulses.

Decomposition:
- No shared package needed. Derived counter widths are localparams computed inside the block.
- One sub-module, `debounce_channel` (params HIST_LEN, HOLD_TICKS, REPEAT_TICKS; ports clk, reset, tick, sync_in, debounced, rise, fall, held), instantiated CHANNELS times in a generate loop.
- Prescaler and synchronisers live in the top.

Test Plan:
Bench parameters for all scenarios: CHANNELS=2, HIST_LEN=4, PRESCALE=4, HOLD_TICKS=8, REPEAT_TICKS=2.
1. Step `buttons[0]` 0->1 at cycle 10 and hold -> debounced[0]=1 between cycles 25 and 28; exactly one rise[0] pulse, 1 clk wide, in the same cycle; fall/held stay 0; channel 1 unaffected.
2. Press ch0 and keep held -> held[0] pulses 8 ticks (32 clk) after debounced rises, then every 2 ticks (8 clk); release -> one fall[0] pulse, no further held.
3. Bounce ch1: toggle every 4 clk for 40 clk, then stable high -> debounced[1] stays 0 during bouncing, then single rise[1]; no spurious fall.
4. Assert both buttons in the same cycle -> rise[0] and rise[1] pulse in the same clk.
5. Assert reset mid-press (debounced[0]=1, hold count 5) -> all outputs 0 immediately, no fall pulse; with button still high after release, rise[0] recurs after 4 ticks.
6. PRESCALE=1, HIST_LEN=2 build: 1-clk glitch -> ignored; 3-clk high pulse -> debounced high for 1 or more clk with rise then fall pulses each 1 clk wide.

Source files
------------

// File: rtl/debounce_channel.sv
// One debounced input: shift-register history with hysteresis, edge pulses,
// and an optional long-press / auto-repeat counter. State moves only on tick.
module debounce_channel #(
    parameter int HIST_LEN     = 8,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync_in,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic held
);

    // The oldest sample only matters after the shift, so it is never stored.
    logic [HIST_LEN-2:0] hist;
    logic [HIST_LEN-1:0] next_hist;
    logic                set_now, clr_now;

    assign next_hist = {hist, sync_in};
    assign set_now   = tick && (&next_hist) && !debounced;
    assign clr_now   = tick && (~|next_hist) && debounced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= set_now;
            fall <= clr_now;
            if (tick)
                hist <= next_hist[HIST_LEN-2:0];
            if (set_now)
                debounced <= 1'b1;
            else if (clr_now)
                debounced <= 1'b0;
        end
    end

    generate
        if (HOLD_TICKS == 0) begin : g_no_hold
            assign held = 1'b0;
        end else begin : g_hold
            localparam int MAX_T = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
            localparam int CW    = $clog2(MAX_T + 1);
            localparam logic [CW-1:0] HOLD_V   = CW'(HOLD_TICKS);
            // A repeat period no shorter than the hold time restarts from zero.
            localparam logic [CW-1:0] RELOAD_V =
                CW'((REPEAT_TICKS < HOLD_TICKS) ? (HOLD_TICKS - REPEAT_TICKS) : 0);

            logic [CW-1:0] cnt, cnt_inc;
            assign cnt_inc = cnt + 1'b1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt  <= '0;
                    held <= 1'b0;
                end else begin
                    held <= 1'b0;
                    if (tick) begin
                        if (!debounced || clr_now) begin
                            cnt <= '0;
                        end else if (!(REPEAT_TICKS == 0 && cnt == HOLD_V)) begin
                            if (cnt_inc == HOLD_V) begin
                                held <= 1'b1;
                                cnt  <= (REPEAT_TICKS == 0) ? HOLD_V : RELOAD_V;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: per-channel 2-flop synchronisers and a
// shared sample prescaler feeding an array of debounce_channel instances.
module debounce_multi #(
    parameter int CHANNELS     = 4,
    parameter int HIST_LEN     = 8,
    parameter int PRESCALE     = 1000,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] buttons,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]       pcnt;
    logic                tick;
    logic [CHANNELS-1:0] sync1, sync2;

    // With PRESCALE=1 the counter is stuck at 0 and tick is always high.
    assign tick = (pcnt == PMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt  <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            pcnt  <= tick ? '0 : pcnt + 1'b1;
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            debounce_channel #(
                .HIST_LEN    (HIST_LEN),
                .HOLD_TICKS  (HOLD_TICKS),
                .REPEAT_TICKS(REPEAT_TICKS)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .tick     (tick),
                .sync_in  (sync2[i]),
                .debounced(debounced[i]),
                .rise     (rise[i]),
                .fall     (fall[i]),
                .held     (held[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: a PRESCALE=4/HIST_LEN=4 build and a
// PRESCALE=1/HIST_LEN=2 build share clock and reset.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] buttons, debounced, rise, fall, held;
    logic [1:0] b2, deb2, rise2, fall2, held2;

    int ncmp, nerr, cyc;
    logic [31:0] acc;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(2), .HIST_LEN(4), .PRESCALE(4),
                     .HOLD_TICKS(8), .REPEAT_TICKS(2)) dut (
        .clk(clk), .reset(reset), .buttons(buttons),
        .debounced(debounced), .rise(rise), .fall(fall), .held(held));

    debounce_multi #(.CHANNELS(2), .HIST_LEN(2), .PRESCALE(1),
                     .HOLD_TICKS(8), .REPEAT_TICKS(2)) dut2 (
        .clk(clk), .reset(reset), .buttons(b2),
        .debounced(deb2), .rise(rise2), .fall(fall2), .held(held2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle n = state just after the n-th rising edge since reset release.
    task automatic adv1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int n);
        while (cyc < n) adv1();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        ncmp = 0; nerr = 0; cyc = 0;
        reset = 1'b1; buttons = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {debounced, rise, fall, held}, 0);
        chk("reset_state2", {deb2, rise2, fall2, held2}, 0);
        reset = 1'b0;
        cyc = 0;

        // Clean press on ch0; ticks land on edges 4,8,12,...
        adv_to(10); buttons[0] = 1'b1;
        acc = 0;
        while (cyc < 27) begin adv1(); acc |= {debounced, rise, fall, held}; end
        chk("t1_quiet_before", acc, 0);
        adv_to(28);
        chk("t1_deb", debounced, 2'b01);
        chk("t1_rise", rise, 2'b01);
        chk("t1_fall_held", {fall, held}, 0);
        adv_to(29);
        chk("t1_rise_width", rise, 2'b00);

        // Long press: held at 8 ticks, then every 2 ticks
        acc = 0;
        while (cyc < 59) begin adv1(); acc |= {held, fall, rise}; end
        chk("t2_no_early_held", acc, 0);
        adv_to(60); chk("t2_held_first", held, 2'b01);
        adv_to(61); chk("t2_held_width", held, 2'b00);
        acc = 0;
        while (cyc < 67) begin adv1(); acc |= held; end
        chk("t2_held_gap", acc, 0);
        adv_to(68); chk("t2_held_repeat", held, 2'b01);
        adv_to(70); buttons[0] = 1'b0;
        adv_to(76); chk("t2_held_during_release", held, 2'b01);
        adv_to(84); chk("t2_held_during_release2", held, 2'b01);
        adv_to(87); chk("t2_deb_before_fall", {debounced, fall}, 4'b0100);
        adv_to(88);
        chk("t2_fall", fall, 2'b01);
        chk("t2_deb_low", debounced, 2'b00);
        chk("t2_held_on_fall", held, 2'b00);
        acc = 0;
        while (cyc < 110) begin adv1(); acc |= {held, fall, rise}; end
        chk("t2_quiet_after", acc, 0);

        // Bouncing ch1 then stable high
        buttons = '0;
        do_reset();
        adv_to(4); buttons[1] = 1'b1;
        acc = 0;
        for (int k = 1; k <= 10; k++) begin
            while (cyc < 4 + 4 * k) begin adv1(); acc |= {debounced, rise, fall}; end
            buttons[1] = (k == 10) ? 1'b1 : ~buttons[1];
        end
        while (cyc < 59) begin adv1(); acc |= {debounced, rise, fall}; end
        chk("t3_bounce_quiet", acc, 0);
        adv_to(60);
        chk("t3_rise", rise, 2'b10);
        chk("t3_deb", debounced, 2'b10);
        adv_to(61); chk("t3_rise_width", rise, 2'b00);
        acc = 0;
        while (cyc < 75) begin adv1(); acc |= fall; end
        chk("t3_no_fall", acc, 0);

        // Simultaneous press
        buttons = '0;
        do_reset();
        adv_to(2); buttons = 2'b11;
        adv_to(19); chk("t4_before", {debounced, rise}, 0);
        adv_to(20);
        chk("t4_rise_both", rise, 2'b11);
        chk("t4_deb_both", debounced, 2'b11);
        adv_to(21); chk("t4_rise_width", rise, 2'b00);

        // Reset with hold count at 5; buttons stay high
        adv_to(41);
        chk("t5_pre_reset", {debounced, held}, 4'b1100);
        reset = 1'b1;
        #2;
        chk("t5_async_clear", {debounced, rise, fall, held}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        acc = 0;
        while (cyc < 15) begin adv1(); acc |= {debounced, rise, fall, held}; end
        chk("t5_requalify_quiet", acc, 0);
        adv_to(16);
        chk("t5_rise_again", rise, 2'b11);
        chk("t5_deb_again", debounced, 2'b11);
        adv_to(17); chk("t5_rise_width", rise, 2'b00);

        // PRESCALE=1, HIST_LEN=2 build
        cyc = 0;
        adv_to(5); b2[0] = 1'b1;
        adv_to(6); b2[0] = 1'b0;
        acc = 0;
        while (cyc < 14) begin adv1(); acc |= {deb2, rise2, fall2, held2}; end
        chk("t6_glitch_ignored", acc, 0);
        adv_to(15); b2[0] = 1'b1;
        adv_to(18); chk("t6_deb_pre", deb2, 2'b00); b2[0] = 1'b0;
        adv_to(19); chk("t6_rise", {deb2, rise2}, 4'b0101);
        adv_to(20); chk("t6_rise_width", {deb2, rise2}, 4'b0100);
        adv_to(21); chk("t6_still_high", {deb2, fall2}, 4'b0100);
        adv_to(22); chk("t6_fall", {deb2, fall2}, 4'b0001);
        adv_to(23); chk("t6_fall_width", {fall2, held2}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
